seg_capture: RTL and testbench
==============================

# seg_capture

Receive-side counterpart of the team's hex-to-7-segment decoder. Monitors a multiplexed, active-high 7-segment display bus (segment lines, decimal point, one-hot digit enables), waits for each digit's pattern to stabilise, and decodes it back to a hex nibble. Once every digit position has been captured, it presents a complete frame on a valid/ready handshake. Used as a self-check and loopback monitor for the display path.

## Interface
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE, 4: consecutive identical synchronised samples required before capture (2..255).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}, active-high, asynchronous to clk.
- dp_in  in  1  decimal-point line, active-high, asynchronous.
- an_in  in  DIGITS  digit enables, active-high; bit i selects position i.
- frame_ready  in  1  consumer accepts the frame.
- frame_valid  out  1  frame outputs hold a complete frame.
- frame_hex  out  4*DIGITS  nibble i in bits [4i+3:4i].
- frame_dp  out  DIGITS  captured decimal point per position.
- frame_blank  out  DIGITS  position showed pattern 0x00.
- frame_err  out  DIGITS  position showed a non-font, non-blank pattern.
- overrun  out  1  sticky: a completed frame was dropped.

## Operation
- Font ({g..a}, hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Blank=00.
- Decode: font hit gives nibble, blank=0, err=0. Pattern 00 gives nibble 0, blank=1, err=0. Any other pattern gives nibble 0, blank=0, err=1.
- Input path: {an_in, dp_in, seg_in} passes through a 2-flop synchroniser. A third register holds the previous synchronised sample.
- Stability counter, 8 bit: reset to 0 when the synchronised sample differs from the previous one; otherwise increments, saturating at STABLE.
- Capture fires exactly once per stable interval, on the cycle the counter reaches STABLE-1 (sample identical for STABLE consecutive cycles). Capture is suppressed when an is zero or not one-hot; nothing is recorded and no error is raised.
- Capture writes slot i (nibble, dp, blank, err) and sets seen[i]. A repeated capture of a slot before frame completion overwrites it; the latest value wins.
- Completion: when seen becomes all-ones (including the capture that sets the last bit), on the next edge:
  - If frame_valid=0, or a transfer (frame_valid && frame_ready) occurs this cycle: slots are copied to the frame outputs, frame_valid=1, seen cleared.
  - Otherwise the completed frame is dropped, seen is cleared, overrun=1, and the outputs are unchanged.
- Transfer without a new completion: frame_valid goes to 0. Outputs keep their values but are don't-care.
- overrun clears on the cycle of a transfer. If a drop occurs on that same cycle, set wins.
- Frame outputs are stable while frame_valid && !frame_ready.

## Timing
- Reset: frame_valid=0, frame_hex=0, frame_dp=0, frame_blank=0, frame_err=0, overrun=0. Also clears seen, slots, synchroniser, and counter. Assertion mid-frame discards the partial frame. The first capture after release needs a full STABLE interval.
- Latency: an input change sampled at edge t is synchronised at t+2. Capture occurs at edge t+2+STABLE-1 if the input stays constant. frame_valid rises one edge after the completing capture.
- Glitches shorter than STABLE synchronised cycles never capture.
- frame_ready is combinationally ignored for outputs: no ready-to-valid path.
- One capture per cycle maximum. Throughput is limited by the display scan rate.

## Structure
- Shared package/include seg_pkg: DIGITS default, SEG_BLANK, font constants SEG_HEX_0..SEG_HEX_F. The team's hex-to-segment decoder is re-pointed at the same constants.
- Sub-module seg_font_decode: combinational, 7-bit pattern in; nibble, blank, err out. Unit-testable exhaustively.
- Top module contains: synchroniser, stability counter, slot registers, seen mask, output/handshake logic.

## Test plan
- DIGITS=4, STABLE=4, frame_ready=1. Scan positions 0..3 with 3F, 06, 5B, 4F, each held 8 cycles. Expected: one frame_valid pulse, frame_hex=0x3210, frame_err=0, frame_blank=0.
- Hold a position 0 pattern for 3 cycles only, then change it. Expected: no capture; seen unchanged; frame_valid stays 0 after the remaining positions are scanned.
- Position 2 shows 0x00 and position 1 shows 0x55 (all held ≥6 cycles). Expected: frame_blank=0100, frame_err=0010, and nibbles 1 and 2 equal 0.
- frame_ready=0; two full scans. Expected: the first frame is held unchanged; the second is dropped; overrun=1. Then raise frame_ready for 1 cycle: frame_valid=0 and overrun=0.
- an_in=0011 held 10 cycles, then a valid scan. Expected: no capture during the 0011 interval; frame content comes only from the valid scan.
- Assert rst_n=0 after positions 0 and 1 are captured, release, then scan positions 2 and 3 only. Expected: frame_valid stays 0 until positions 0 and 1 are re-captured; all outputs read 0 during reset.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared 7-segment font constants, defaults and helpers used
//                by the display path and the seg_capture loopback monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int DIGITS_DEFAULT = 4;
    localparam int STABLE_DEFAULT = 4;

    // Segment patterns are {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    // True when exactly one bit is set; digit enables are zero-extended to 8 bits.
    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_font_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg_font_decode
//  Description : Combinational inverse of the hex-to-7-segment font. Maps a
//                segment pattern back to a nibble and flags blank / unknown.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_font_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    // Font lookup; anything that is neither a glyph nor blank is an error.
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg_capture
//  Description : Monitors a multiplexed 7-segment bus, captures each digit
//                once its pattern is stable, and hands out complete frames on
//                a valid/ready interface with a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_capture
    import seg_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT,
    parameter int STABLE = STABLE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic                  dp_in,
    input  logic [DIGITS-1:0]     an_in,
    input  logic                  frame_ready,
    output logic                  frame_valid,
    output logic [4*DIGITS-1:0]   frame_hex,
    output logic [DIGITS-1:0]     frame_dp,
    output logic [DIGITS-1:0]     frame_blank,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  overrun
);

    localparam int         SAMPLE_W   = DIGITS + 8;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE);
    // Counter value just before the edge on which it reaches STABLE-1.
    localparam logic [7:0] CAPTURE_AT = 8'(STABLE - 2);

    // Input path: two synchroniser stages plus the previous synchronised sample.
    logic [SAMPLE_W-1:0] sync1_q, sync1_d;
    logic [SAMPLE_W-1:0] sync2_q, sync2_d;
    logic [SAMPLE_W-1:0] prev_q,  prev_d;
    logic [7:0]          cnt_q,   cnt_d;

    // Per-position capture slots and the mask of positions captured so far.
    logic [4*DIGITS-1:0] slot_hex_q,   slot_hex_d;
    logic [DIGITS-1:0]   slot_dp_q,    slot_dp_d;
    logic [DIGITS-1:0]   slot_blank_q, slot_blank_d;
    logic [DIGITS-1:0]   slot_err_q,   slot_err_d;
    logic [DIGITS-1:0]   seen_q,       seen_d;

    // Frame output registers.
    logic                valid_q,   valid_d;
    logic [4*DIGITS-1:0] hex_q,     hex_d;
    logic [DIGITS-1:0]   dp_q,      dp_d;
    logic [DIGITS-1:0]   blank_q,   blank_d;
    logic [DIGITS-1:0]   err_q,     err_d;
    logic                overrun_q, overrun_d;

    logic [DIGITS-1:0]   w_an;
    logic                w_dp;
    logic [6:0]          w_seg;
    logic                w_same;
    logic                w_capture;
    logic [3:0]          w_nibble;
    logic                w_blank;
    logic                w_err;
    logic                w_xfer;
    logic                w_complete;

    assign w_an       = sync2_q[SAMPLE_W-1:8];
    assign w_dp       = sync2_q[7];
    assign w_seg      = sync2_q[6:0];
    assign w_same     = (sync2_q == prev_q);
    assign w_xfer     = valid_q && frame_ready;
    assign w_complete = &seen_q;

    seg_font_decode u_decode (
        .seg    (w_seg),
        .nibble (w_nibble),
        .blank  (w_blank),
        .err    (w_err)
    );

    // Synchroniser shift and stability counter (clears on change, saturates at STABLE).
    always_comb begin
        sync1_d = {an_in, dp_in, seg_in};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = cnt_q;
        if (!w_same) begin
            cnt_d = 8'd0;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Single capture per stable interval; blank or multi-hot enables are ignored silently.
    always_comb begin
        w_capture = w_same && (cnt_q == CAPTURE_AT) && is_onehot8(8'(w_an));
    end

    // Slot writes and seen tracking; a completing frame clears seen, a concurrent capture re-seeds it.
    always_comb begin
        slot_hex_d   = slot_hex_q;
        slot_dp_d    = slot_dp_q;
        slot_blank_d = slot_blank_q;
        slot_err_d   = slot_err_q;
        seen_d       = w_complete ? '0 : seen_q;
        if (w_capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_an[i]) begin
                    slot_hex_d[4*i +: 4] = w_nibble;
                    slot_dp_d[i]         = w_dp;
                    slot_blank_d[i]      = w_blank;
                    slot_err_d[i]        = w_err;
                    seen_d[i]            = 1'b1;
                end
            end
        end
    end

    // Frame handoff: load on completion when the output is free, otherwise drop and flag overrun.
    always_comb begin
        valid_d   = valid_q;
        hex_d     = hex_q;
        dp_d      = dp_q;
        blank_d   = blank_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        if (w_xfer) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (w_complete) begin
            if (!valid_q || w_xfer) begin
                valid_d = 1'b1;
                hex_d   = slot_hex_q;
                dp_d    = slot_dp_q;
                blank_d = slot_blank_q;
                err_d   = slot_err_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            cnt_q        <= 8'd0;
            slot_hex_q   <= '0;
            slot_dp_q    <= '0;
            slot_blank_q <= '0;
            slot_err_q   <= '0;
            seen_q       <= '0;
            valid_q      <= 1'b0;
            hex_q        <= '0;
            dp_q         <= '0;
            blank_q      <= '0;
            err_q        <= '0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            slot_hex_q   <= slot_hex_d;
            slot_dp_q    <= slot_dp_d;
            slot_blank_q <= slot_blank_d;
            slot_err_q   <= slot_err_d;
            seen_q       <= seen_d;
            valid_q      <= valid_d;
            hex_q        <= hex_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign frame_valid = valid_q;
    assign frame_hex   = hex_q;
    assign frame_dp    = dp_q;
    assign frame_blank = blank_q;
    assign frame_err   = err_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_capture
//  Description : Directed scoreboard bench for seg_capture (DIGITS=4, STABLE=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_capture;

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [3:0]  an_in;
    logic        frame_ready;
    logic        frame_valid;
    logic [15:0] frame_hex;
    logic [3:0]  frame_dp;
    logic [3:0]  frame_blank;
    logic [3:0]  frame_err;
    logic        overrun;

    int     checks = 0;
    int     errors = 0;
    int     xfers  = 0;
    frame_t exp_q[$];

    seg_capture #(.DIGITS(4), .STABLE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .an_in       (an_in),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_hex   (frame_hex),
        .frame_dp    (frame_dp),
        .frame_blank (frame_blank),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold one bus value for n sampling edges; returns 1 time unit after the last edge.
    task automatic show(input logic [3:0] an, input logic dp, input logic [6:0] seg, input int n);
        an_in  = an;
        dp_in  = dp;
        seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic frame_t mk(input logic [15:0] h, input logic [3:0] d,
                                  input logic [3:0] b, input logic [3:0] e);
        frame_t f;
        f.hex = h; f.dp = d; f.blank = b; f.err = e;
        return f;
    endfunction

    // Scoreboard: every accepted frame is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            frame_t e;
            xfers++;
            chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("frame_hex",   32'(frame_hex),   32'(e.hex));
                chk("frame_dp",    32'(frame_dp),    32'(e.dp));
                chk("frame_blank", 32'(frame_blank), 32'(e.blank));
                chk("frame_err",   32'(frame_err),   32'(e.err));
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        seg_in      = 7'h00;
        dp_in       = 1'b0;
        an_in       = 4'h0;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",   32'(frame_valid), 32'd0);
        chk("rst_hex",     32'(frame_hex),   32'd0);
        chk("rst_dp",      32'(frame_dp),    32'd0);
        chk("rst_blank",   32'(frame_blank), 32'd0);
        chk("rst_err",     32'(frame_err),   32'd0);
        chk("rst_overrun", 32'(overrun),     32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic scan 0,1,2,3.
        exp_q.push_back(mk(16'h3210, 4'h0, 4'h0, 4'h0));
        show(4'b0001, 1'b0, 7'h3F, 8);
        show(4'b0010, 1'b0, 7'h06, 8);
        show(4'b0100, 1'b0, 7'h5B, 8);
        show(4'b1000, 1'b0, 7'h4F, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t1_xfers", 32'(xfers), 32'd1);

        // Short glitch on position 0 must not capture.
        show(4'b0001, 1'b0, 7'h3F, 3);
        show(4'b0000, 1'b0, 7'h00, 8);
        show(4'b0010, 1'b0, 7'h06, 8);
        show(4'b0100, 1'b0, 7'h5B, 8);
        show(4'b1000, 1'b0, 7'h4F, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t2_no_frame", 32'(xfers), 32'd1);
        exp_q.push_back(mk(16'h3216, 4'h0, 4'h0, 4'h0));
        show(4'b0001, 1'b0, 7'h7D, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t2_xfers", 32'(xfers), 32'd2);

        // Blank, unknown pattern and decimal point.
        exp_q.push_back(mk(16'hF009, 4'b0001, 4'b0100, 4'b0010));
        show(4'b0001, 1'b1, 7'h6F, 8);
        show(4'b0010, 1'b0, 7'h55, 8);
        show(4'b0100, 1'b0, 7'h00, 8);
        show(4'b1000, 1'b0, 7'h71, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t3_xfers", 32'(xfers), 32'd3);

        // Back-pressure: first frame held, second dropped with overrun.
        frame_ready = 1'b0;
        show(4'b0001, 1'b0, 7'h66, 8);
        show(4'b0010, 1'b0, 7'h4F, 8);
        show(4'b0100, 1'b0, 7'h5B, 8);
        show(4'b1000, 1'b0, 7'h06, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t4_valid1",   32'(frame_valid), 32'd1);
        chk("t4_hex1",     32'(frame_hex),   32'h1234);
        chk("t4_ovr1",     32'(overrun),     32'd0);
        show(4'b0001, 1'b0, 7'h7F, 8);
        show(4'b0010, 1'b0, 7'h7F, 8);
        show(4'b0100, 1'b0, 7'h7F, 8);
        show(4'b1000, 1'b0, 7'h7F, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t4_valid2",   32'(frame_valid), 32'd1);
        chk("t4_hex2",     32'(frame_hex),   32'h1234);
        chk("t4_ovr2",     32'(overrun),     32'd1);
        exp_q.push_back(mk(16'h1234, 4'h0, 4'h0, 4'h0));
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_valid3",   32'(frame_valid), 32'd0);
        chk("t4_ovr3",     32'(overrun),     32'd0);
        chk("t4_xfers",    32'(xfers),       32'd4);

        // Multi-hot enables are ignored.
        show(4'b0011, 1'b0, 7'h3F, 10);
        show(4'b0100, 1'b0, 7'h7C, 8);
        show(4'b1000, 1'b0, 7'h77, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t5_no_frame", 32'(xfers), 32'd4);
        exp_q.push_back(mk(16'hABCD, 4'h0, 4'h0, 4'h0));
        show(4'b0001, 1'b0, 7'h5E, 8);
        show(4'b0010, 1'b0, 7'h39, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t5_xfers", 32'(xfers), 32'd5);

        // Reset mid-frame discards the captured positions.
        show(4'b0001, 1'b0, 7'h06, 8);
        show(4'b0010, 1'b0, 7'h5B, 8);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_valid", 32'(frame_valid), 32'd0);
        chk("t6_rst_hex",   32'(frame_hex),   32'd0);
        chk("t6_rst_dp",    32'(frame_dp),    32'd0);
        chk("t6_rst_blank", 32'(frame_blank), 32'd0);
        chk("t6_rst_err",   32'(frame_err),   32'd0);
        chk("t6_rst_ovr",   32'(overrun),     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        show(4'b0100, 1'b0, 7'h79, 8);
        show(4'b1000, 1'b0, 7'h07, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t6_no_frame", 32'(xfers), 32'd5);
        exp_q.push_back(mk(16'h7E50, 4'h0, 4'h0, 4'h0));
        show(4'b0001, 1'b0, 7'h3F, 8);
        show(4'b0010, 1'b0, 7'h6D, 8);
        show(4'b0000, 1'b0, 7'h00, 12);
        chk("t6_xfers",   32'(xfers),        32'd6);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
